// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// keypad_pkg : shared types, sizes and row-decode helpers for keypad_scanner
// Revision   : 1.0
// ============================================================================
package keypad_pkg;

  localparam int NUM_FILAS = 4;
  localparam int NUM_COLS  = 4;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    EMIT         = 2'd2,
    WAIT_RELEASE = 2'd3
  } estado_t;

  typedef logic [3:0] tecla_t;

  // A press is only a row vector with exactly one bit set; ghosting patterns are rejected.
  function automatic logic es_onehot(input logic [NUM_FILAS-1:0] v);
    return (v != '0) && ((v & (v - NUM_FILAS'(1))) == '0);
  endfunction

  function automatic logic [1:0] indice_fila(input logic [NUM_FILAS-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_FILAS; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// sync_2ff : parameterized-width two-flop synchronizer for asynchronous inputs
// Revision : 1.0
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner : 4x4 matrix keypad scan, debounce and valid/ready key output
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN
// Revision       : 1.0
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic                 clk,
  input  logic                 rst_n_pi,
  input  logic [NUM_FILAS-1:0] filas_pi,
  output logic [NUM_COLS-1:0]  columnas_po,
  output tecla_t               tecla_o,
  output logic                 valido_o,
  input  logic                 listo_pi
);

  localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_FILAS-1:0] filas_s;
  estado_t              estado_q;
  logic [1:0]           col_q;
  logic [1:0]           fila_q;
  logic [SCAN_W-1:0]    dwell_q;
  logic [DEB_W-1:0]     estable_q;
  tecla_t               tecla_q;
  logic                 valido_q;
  logic                 coincide;

  sync_2ff #(
    .WIDTH (NUM_FILAS)
  ) u_sync_filas (
    .clk     (clk),
    .rst_n_i (rst_n_pi),
    .d_i     (filas_pi),
    .q_o     (filas_s)
  );

  assign coincide = (filas_s == (NUM_FILAS'(1) << fila_q));

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_q;
`endif

  // estable_q serves both the press debounce and the release debounce; it is cleared on entry to each.
  always_ff @(posedge clk or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      estado_q  <= SCAN;
      col_q     <= 2'd0;
      fila_q    <= 2'd0;
      dwell_q   <= '0;
      estable_q <= '0;
      tecla_q   <= '0;
      valido_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      case (estado_q)
        SCAN: begin
          if (dwell_q == SCAN_LAST) begin
            dwell_q <= '0;
            if (es_onehot(filas_s)) begin
              fila_q    <= indice_fila(filas_s);
              estable_q <= '0;
              estado_q  <= DEBOUNCE;
            end else begin
              col_q <= col_q + 2'd1;
            end
          end else begin
            dwell_q <= dwell_q + SCAN_W'(1);
          end
        end
        DEBOUNCE: begin
          if (coincide) begin
            if (estable_q == DEB_LAST) begin
              tecla_q  <= {fila_q, col_q};
              valido_q <= 1'b1;
              estado_q <= EMIT;
            end else begin
              estable_q <= estable_q + DEB_W'(1);
            end
          end else begin
            dwell_q  <= '0;
            estado_q <= SCAN;
          end
        end
        EMIT: begin
          if (listo_pi) begin
            valido_q  <= 1'b0;
            estable_q <= '0;
            estado_q  <= WAIT_RELEASE;
`ifdef KEYPAD_REPEAT_EN
            rep_q     <= '0;
`endif
          end
        end
        WAIT_RELEASE: begin
          if (filas_s == '0) begin
            if (estable_q == DEB_LAST) begin
              col_q    <= col_q + 2'd1;
              dwell_q  <= '0;
              estado_q <= SCAN;
            end else begin
              estable_q <= estable_q + DEB_W'(1);
            end
          end else begin
            estable_q <= '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (coincide) begin
            if (rep_q == REP_LAST) begin
              rep_q    <= '0;
              valido_q <= 1'b1;
              estado_q <= EMIT;
            end else begin
              rep_q <= rep_q + REP_W'(1);
            end
          end else begin
            rep_q <= '0;
          end
`endif
        end
        default: estado_q <= SCAN;
      endcase
    end
  end

  assign columnas_po = NUM_COLS'(1) << col_q;
  assign tecla_o     = tecla_q;
  assign valido_o    = valido_q;

endmodule
`default_nettype wire
